fw_version_reporter: RTL and testbench

FW_VERSION_REPORTER -- requirements
Module: fw_version_reporter

---
 rtl/fw_version_reporter.sv | 125 ++++++++++++
 tb/tb_fw_version_reporter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_version_reporter.sv
// Streams a 6-byte firmware version packet (sync, id, major, minor, patch, xor) on req.
// First byte valid one cycle after req; valid/ready per byte, aborts after TIMEOUT_CYCLES stalls.
module fw_version_reporter #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  PKT_ID         = 8'h56,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] major,
  input  logic [7:0] minor,
  input  logic [7:0] patch,
  input  logic       req,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef struct packed {
    logic [7:0] major;
    logic [7:0] minor;
    logic [7:0] patch;
  } ver_t;

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TIMEOUT_M1 = TIMEOUT - 16'd1;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [15:0] stall_cnt, stall_cnt_nxt;
  ver_t        ver_q;
  logic        latch;
  logic        done_nxt, err_nxt;
  logic        xfer, stall, timeout_hit;
  logic [7:0]  chk;

  assign tx_valid    = (state == SEND);
  assign busy        = (state == SEND);
  assign tx_last     = (state == SEND) && (idx == 3'd5);
  assign xfer        = tx_valid && tx_ready;
  assign stall       = tx_valid && !tx_ready;
  // Abort on the stall cycle that brings the count up to TIMEOUT; a ready cycle always transfers.
  assign timeout_hit = (TIMEOUT != 16'd0) && stall && (stall_cnt == TIMEOUT_M1);
  assign chk         = SYNC_BYTE ^ PKT_ID ^ ver_q.major ^ ver_q.minor ^ ver_q.patch;

  always_comb begin
    tx_data = 8'h00;
    if (state == SEND) begin
      case (idx)
        3'd0:    tx_data = SYNC_BYTE;
        3'd1:    tx_data = PKT_ID;
        3'd2:    tx_data = ver_q.major;
        3'd3:    tx_data = ver_q.minor;
        3'd4:    tx_data = ver_q.patch;
        default: tx_data = chk;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    stall_cnt_nxt = stall_cnt;
    latch         = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          latch         = 1'b1;
          idx_nxt       = 3'd0;
          stall_cnt_nxt = 16'd0;
          state_nxt     = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          stall_cnt_nxt = 16'd0;
          if (idx == 3'd5) begin
            state_nxt = IDLE;
            idx_nxt   = 3'd0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else if (timeout_hit) begin
          state_nxt     = IDLE;
          idx_nxt       = 3'd0;
          stall_cnt_nxt = 16'd0;
          err_nxt       = 1'b1;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
          stall_cnt_nxt = stall_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      stall_cnt <= 16'd0;
      ver_q     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      stall_cnt <= stall_cnt_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      if (latch) begin
        ver_q <= '{major: major, minor: minor, patch: patch};
      end
    end
  end

endmodule

// File: tb/tb_fw_version_reporter.sv
// Scoreboard bench for fw_version_reporter: directed packets, backpressure, timeout, reset.
module tb_fw_version_reporter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] major = 8'h00;
  logic [7:0] minor = 8'h00;
  logic [7:0] patch = 8'h00;
  logic       req = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, busy, done, err;

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q[$];   // {last, data}
  logic [1:0] evt_q[$];   // 2'b10 = done, 2'b01 = err

  always #5 clk = ~clk;

  fw_version_reporter #(.SYNC_BYTE(8'hA5), .PKT_ID(8'h56), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .major(major), .minor(minor), .patch(patch),
    .req(req), .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [7:0] ma, input logic [7:0] mi, input logic [7:0] pa,
                          input logic [7:0] ck, input int nbytes, input logic [1:0] ev);
    logic [7:0] b [6];
    b[0] = 8'hA5; b[1] = 8'h56; b[2] = ma; b[3] = mi; b[4] = pa; b[5] = ck;
    for (int i = 0; i < nbytes; i++) exp_q.push_back({(i == 5), b[i]});
    if (ev != 2'b00) evt_q.push_back(ev);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 40) begin
      cyc();
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  // Monitor: pops the scoreboard on every transfer and every done/err pulse.
  initial begin : monitor
    logic       prev_stall;
    logic [8:0] prev_dat;
    logic [8:0] e;
    logic [1:0] ev;
    prev_stall = 1'b0;
    prev_dat   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && tx_valid)
          check("hold_during_stall", {23'd0, tx_last, tx_data}, {23'd0, prev_dat});
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_byte: got %0h, expected none", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("byte", {23'd0, tx_last, tx_data}, {23'd0, e});
          end
        end
        if (done || err) begin
          if (evt_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_event: got done=%0b err=%0b, expected none", done, err);
          end else begin
            ev = evt_q.pop_front();
            check("event", {30'd0, done, err}, {30'd0, ev});
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_dat   = {tx_last, tx_data};
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Reset state
    #1;
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_last",  {31'd0, tx_last},  32'd0);
    check("rst_data",  {24'd0, tx_data},  32'd0);
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_done",  {31'd0, done},     32'd0);
    check("rst_err",   {31'd0, err},      32'd0);
    #1 rst_n = 1'b1;

    // Basic packet, ready always high; first edge after reset honours req
    major = 8'd11; minor = 8'd1; patch = 8'd1; tx_ready = 1'b1; req = 1'b1;
    push_pkt(8'h0B, 8'h01, 8'h01, 8'hF8, 6, 2'b10);
    cyc();
    req = 1'b0;
    check("t1_first_valid", {31'd0, tx_valid}, 32'd1);
    check("t1_first_byte",  {24'd0, tx_data},  32'hA5);
    check("t1_busy",        {31'd0, busy},     32'd1);
    repeat (6) cyc();
    check("t1_done_timing", {31'd0, done},     32'd1);
    check("t1_valid_drop",  {31'd0, tx_valid}, 32'd0);
    check("t1_busy_drop",   {31'd0, busy},     32'd0);
    cyc();
    check("t1_done_pulse",  {31'd0, done},     32'd0);

    // Ready toggling 1/0: last transfer 11 cycles after first valid
    req = 1'b1;
    push_pkt(8'h0B, 8'h01, 8'h01, 8'hF8, 6, 2'b10);
    cyc();
    req = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tx_ready = (i % 2 == 0);
      cyc();
    end
    check("t2_done_timing", {31'd0, done}, 32'd1);
    tx_ready = 1'b1;
    cyc();

    // Timeout: stall at byte 2 for 4 cycles
    req = 1'b1;
    push_pkt(8'h0B, 8'h01, 8'h01, 8'hF8, 2, 2'b01);
    cyc();
    req = 1'b0;
    cyc(); cyc();
    tx_ready = 1'b0;
    repeat (3) cyc();
    check("t3_still_valid", {31'd0, tx_valid}, 32'd1);
    check("t3_stalled_byte", {24'd0, tx_data}, 32'h0B);
    cyc();
    check("t3_abort_valid", {31'd0, tx_valid}, 32'd0);
    check("t3_err",         {31'd0, err},      32'd1);
    check("t3_no_done",     {31'd0, done},     32'd0);
    check("t3_busy",        {31'd0, busy},     32'd0);
    cyc();
    check("t3_err_pulse",   {31'd0, err},      32'd0);
    tx_ready = 1'b1; req = 1'b1;
    push_pkt(8'h0B, 8'h01, 8'h01, 8'hF8, 6, 2'b10);
    cyc();
    req = 1'b0;
    check("t3_restart_a5", {24'd0, tx_data}, 32'hA5);
    wait_done("t3_restart_done");
    cyc();

    // Ready returns on the cycle the count would reach the limit: transfer wins
    req = 1'b1;
    push_pkt(8'h0B, 8'h01, 8'h01, 8'hF8, 6, 2'b10);
    cyc();
    req = 1'b0;
    cyc(); cyc();
    tx_ready = 1'b0;
    repeat (3) cyc();
    tx_ready = 1'b1;
    wait_done("t3b_done");
    cyc();

    // req during byte 3 and the final transfer ignored; req in done cycle accepted
    req = 1'b1;
    push_pkt(8'h0B, 8'h01, 8'h01, 8'hF8, 6, 2'b10);
    cyc();
    req = 1'b0;
    repeat (3) cyc();
    req = 1'b1;
    cyc();
    req = 1'b0;
    cyc();
    check("t4_last_flag", {31'd0, tx_last}, 32'd1);
    req = 1'b1;
    cyc();
    req = 1'b0;
    check("t4_done", {31'd0, done}, 32'd1);
    major = 8'd2; minor = 8'd3; patch = 8'd4; req = 1'b1;
    push_pkt(8'h02, 8'h03, 8'h04, 8'hF6, 6, 2'b10);
    cyc();
    req = 1'b0;
    check("t4_second_a5", {24'd0, tx_data}, 32'hA5);
    wait_done("t4_second_done");
    cyc();

    // Version changes while byte 1 stalls do not reach the packet
    major = 8'd11; minor = 8'd1; patch = 8'd1; req = 1'b1;
    push_pkt(8'h0B, 8'h01, 8'h01, 8'hF8, 6, 2'b10);
    cyc();
    req = 1'b0;
    cyc();
    tx_ready = 1'b0;
    major = 8'd12;
    cyc(); cyc();
    check("t5_stall_byte", {24'd0, tx_data}, 32'h56);
    tx_ready = 1'b1;
    wait_done("t5_done");
    cyc();

    // Reset while byte 4 stalls
    major = 8'd11; req = 1'b1;
    push_pkt(8'h0B, 8'h01, 8'h01, 8'hF8, 4, 2'b00);
    cyc();
    req = 1'b0;
    repeat (4) cyc();
    tx_ready = 1'b0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, tx_valid}, 32'd0);
    check("t6_last",  {31'd0, tx_last},  32'd0);
    check("t6_data",  {24'd0, tx_data},  32'd0);
    check("t6_busy",  {31'd0, busy},     32'd0);
    check("t6_done",  {31'd0, done},     32'd0);
    check("t6_err",   {31'd0, err},      32'd0);
    cyc();
    #2 rst_n = 1'b1;
    tx_ready = 1'b1; req = 1'b1;
    push_pkt(8'h0B, 8'h01, 8'h01, 8'hF8, 6, 2'b10);
    cyc();
    req = 1'b0;
    check("t6_after_rst_a5", {24'd0, tx_data}, 32'hA5);
    wait_done("t6_after_rst_done");

    repeat (3) cyc();
    check("bytes_drained",  exp_q.size(), 32'd0);
    check("events_drained", evt_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
